// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//
// Loads a program image into instruction memory from a byte stream while
// holding the CPU. The stream is a 2-byte big-endian word count N followed by
// N 32-bit words, each sent most-significant byte first. One memory write is
// issued per completed word, and the CPU is released when the last word has
// been written.
//
// Parameters
//   ADDR_W      instruction-memory word-address width (DEPTH = 2**ADDR_W),
//               supported range 1..16
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-high reset
//   start       one-cycle request to begin a load session
//   byte_valid  a stream byte is offered on byte_data
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle (transfer = valid & ready)
//   im_we       instruction-memory write strobe, one cycle per word
//   im_addr     word address of the write
//   im_wdata    instruction word being written
//   cpu_hold    keeps the CPU frozen while high
//   done        one-cycle pulse when a session completes successfully
//   error       level, set when the length header is zero or too large
// ---------------------------------------------------------------------------
module instr_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_t;

   state_t      state;
   logic [15:0] count;
   logic [16:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] assembly;

   logic        xfer;
   logic [15:0] count_full;
   logic        len_bad;
   logic        more_words;

   // A byte moves only when the loader is ready and the source offers one.
   // byte_ready is a registered output, so this is a clean same-cycle
   // handshake with no combinational path from byte_valid back to ready.
   assign xfer = byte_valid & byte_ready;

   // The full word count as it will be once the low header byte lands. The
   // count is widened before comparing so that N == DEPTH stays legal even
   // when DEPTH itself does not fit in 16 bits of a signed compare.
   assign count_full = {count[15:8], byte_data};
   assign len_bad    = (count_full == 16'd0) ||
                       ({16'd0, count_full} > 32'(DEPTH));

   // The word index is one bit wider than the count so that the last word
   // of a full-depth image does not make index+1 wrap back to zero.
   assign more_words = (word_idx + 17'd1) < {1'b0, count};

   // Single state machine with every output registered. Outputs are updated
   // together with the state transition so that, in any given cycle, they
   // reflect the state the machine is currently in. Only the three most
   // recent bytes of a word are kept in the assembly register; the fourth
   // byte goes straight into im_wdata on its way into WRITE, which is what
   // gives the one-cycle latency from the last byte to the write strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         byte_ready <= 1'b0;
         im_we      <= 1'b0;
         im_addr    <= '0;
         im_wdata   <= '0;
         cpu_hold   <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         count      <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         assembly   <= '0;
      end else begin
         case (state)
            // Waiting for a session. The CPU runs freely here.
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= LEN_HI;
                  byte_ready <= 1'b1;
                  cpu_hold   <= 1'b1;
                  count      <= '0;
                  word_idx   <= '0;
                  byte_idx   <= '0;
                  assembly   <= '0;
               end
            end

            // High byte of the word count.
            LEN_HI: begin
               if (xfer) begin
                  count[15:8] <= byte_data;
                  state       <= LEN_LO;
               end
            end

            // Low byte of the word count, then validate the whole count.
            LEN_LO: begin
               if (xfer) begin
                  count[7:0] <= byte_data;
                  word_idx   <= '0;
                  byte_idx   <= '0;
                  if (len_bad) begin
                     state      <= ERR;
                     byte_ready <= 1'b0;
                     error      <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end

            // Collect four bytes, MSB first. On the fourth, present the word
            // to instruction memory for exactly one cycle.
            DATA: begin
               if (xfer) begin
                  assembly <= {assembly[15:0], byte_data};
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     state      <= WRITE;
                     byte_ready <= 1'b0;
                     im_we      <= 1'b1;
                     im_addr    <= word_idx[ADDR_W-1:0];
                     im_wdata   <= {assembly, byte_data};
                  end
               end
            end

            // The write strobe is high for this single cycle. Decide whether
            // another word follows or the image is complete.
            WRITE: begin
               im_we    <= 1'b0;
               word_idx <= word_idx + 17'd1;
               byte_idx <= '0;
               if (more_words) begin
                  state      <= DATA;
                  byte_ready <= 1'b1;
               end else begin
                  state    <= DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end
            end

            // done is high for exactly this one cycle.
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            // Bad header: keep the CPU held and ignore everything except a
            // fresh start, which clears the error and retries the header.
            ERR: begin
               if (start) begin
                  state      <= LEN_HI;
                  error      <= 1'b0;
                  byte_ready <= 1'b1;
                  cpu_hold   <= 1'b1;
                  count      <= '0;
                  word_idx   <= '0;
                  byte_idx   <= '0;
                  assembly   <= '0;
               end
            end

            default: begin
               state      <= IDLE;
               byte_ready <= 1'b0;
               im_we      <= 1'b0;
               cpu_hold   <= 1'b0;
               done       <= 1'b0;
               error      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
//
// Self-checking bench for instr_loader (ADDR_W = 8). Byte streams are built
// here, and the expected list of memory writes is derived straight from the
// stream format: the header gives N, and word i is bytes 2+4i..5+4i, packed
// MSB first, written to address i. A monitor records every write the DUT
// actually makes, plus any handshake rule violation it sees.
// ---------------------------------------------------------------------------
module tb_instr_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk;
   logic              reset;
   logic              start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;

   int errors = 0;
   int checks = 0;

   logic [7:0]  stream[$];
   int          expAddr[$];
   logic [31:0] expData[$];
   logic        expErr;

   int          obsAddr[$];
   logic [31:0] obsData[$];
   int          doneCount  = 0;
   int          weReadyBad = 0;
   int          holdBad    = 0;

   instr_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .im_we      (im_we),
      .im_addr    (im_addr),
      .im_wdata   (im_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Mid-cycle monitor: log every memory write and note any cycle where the
   // loader writes while also accepting bytes, lets the CPU run while busy,
   // or signals done while still holding the CPU.
   always @(negedge clk) begin
      if (im_we) begin
         obsAddr.push_back(int'(im_addr));
         obsData.push_back(im_wdata);
         if (byte_ready) weReadyBad++;
      end
      if ((im_we || byte_ready) && !cpu_hold) holdBad++;
      if (done) begin
         doneCount++;
         if (cpu_hold) holdBad++;
      end
   end

   // One comparison: counted, and reported on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Header plus nWords of random payload.
   task automatic makeStream(input logic [15:0] hdr, input int nWords);
      stream.delete();
      stream.push_back(hdr[15:8]);
      stream.push_back(hdr[7:0]);
      for (int i = 0; i < nWords * 4; i++) stream.push_back(8'($urandom));
   endtask

   // Reference model: what the stream should produce, from the format alone.
   task automatic buildExpected();
      int n;
      n = (int'(stream[0]) << 8) | int'(stream[1]);
      expAddr.delete();
      expData.delete();
      expErr = (n == 0) || (n > DEPTH);
      if (!expErr) begin
         for (int i = 0; i < n; i++) begin
            expAddr.push_back(i);
            expData.push_back({stream[2+4*i], stream[3+4*i],
                               stream[4+4*i], stream[5+4*i]});
         end
      end
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offer stream bytes, with byte_valid dropped gapPct percent of the time.
   // A byte counts as taken only if ready was high during its cycle. start
   // can be pulsed once mid-stream, when startAt bytes have been taken.
   task automatic applyStimulus(input int gapPct, input int startAt,
                                input int maxBytes);
      int idx;
      int cycles;
      bit pulsed;
      int limit;
      idx    = 0;
      cycles = 0;
      pulsed = 0;
      limit  = (maxBytes < stream.size()) ? maxBytes : stream.size();
      while (idx < limit && cycles < 20000) begin
         byte_valid = ($urandom_range(99) >= gapPct);
         byte_data  = byte_valid ? stream[idx] : 8'($urandom);
         if (!pulsed && idx == startAt) begin
            start  = 1'b1;
            pulsed = 1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (byte_valid && byte_ready) idx++;
         @(posedge clk); #1;
         cycles++;
      end
      byte_valid = 1'b0;
      start      = 1'b0;
      checkOutput("bytes_taken", idx, limit);
   endtask

   // Full session: start, stream, wait for the outcome, compare with model.
   task automatic runSession(input string name, input int gapPct,
                             input int startAt);
      int d0;
      int waited;
      buildExpected();
      obsAddr.delete();
      obsData.delete();
      weReadyBad = 0;
      holdBad    = 0;
      d0         = doneCount;
      pulseStart();
      checkOutput({name, "_started_err"}, error, 0);
      checkOutput({name, "_started_hold"}, cpu_hold, 1);
      checkOutput({name, "_started_ready"}, byte_ready, 1);
      applyStimulus(gapPct, startAt, stream.size());
      if (expErr) begin
         repeat (3) @(posedge clk);
         #1;
         checkOutput({name, "_error"}, error, 1);
         checkOutput({name, "_err_hold"}, cpu_hold, 1);
         checkOutput({name, "_err_ready"}, byte_ready, 0);
         checkOutput({name, "_err_done"}, doneCount - d0, 0);
      end else begin
         waited = 0;
         while (doneCount == d0 && waited < 50) begin
            @(posedge clk); #2;
            waited++;
         end
         checkOutput({name, "_done_pulses"}, doneCount - d0, 1);
         @(posedge clk); #1;
         checkOutput({name, "_idle_done"}, done, 0);
         checkOutput({name, "_idle_hold"}, cpu_hold, 0);
         checkOutput({name, "_error"}, error, 0);
      end
      checkOutput({name, "_nwrites"}, obsAddr.size(), expAddr.size());
      for (int i = 0; i < expAddr.size() && i < obsAddr.size(); i++) begin
         checkOutput({name, "_addr"}, obsAddr[i], expAddr[i]);
         checkOutput({name, "_data"}, obsData[i], expData[i]);
      end
      checkOutput({name, "_we_with_ready"}, weReadyBad, 0);
      checkOutput({name, "_hold_rule"}, holdBad, 0);
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "_ready"}, byte_ready, 0);
      checkOutput({name, "_we"}, im_we, 0);
      checkOutput({name, "_addr"}, im_addr, 0);
      checkOutput({name, "_wdata"}, im_wdata, 0);
      checkOutput({name, "_hold"}, cpu_hold, 0);
      checkOutput({name, "_done"}, done, 0);
      checkOutput({name, "_error"}, error, 0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("rst");
      reset = 1'b0;
      @(posedge clk); #1;

      // Reference two-word program.
      stream = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'hAC, 8'h08, 8'h00, 8'h00};
      runSession("two_word", 0, -1);

      // Zero-length header, then a good one-word retry out of ERR.
      makeStream(16'h0000, 0);
      runSession("len_zero", 0, -1);
      makeStream(16'h0001, 1);
      runSession("retry_one", 0, -1);

      // One past full depth is rejected; exactly full depth is accepted.
      makeStream(16'h0101, 0);
      runSession("len_257", 0, -1);
      makeStream(16'h0100, 256);
      runSession("len_256", 0, -1);
      checkOutput("len_256_last_addr", obsAddr.size() > 0 ? obsAddr[$] : -1, 255);

      // Random stalls inside words must not change the written sequence.
      makeStream(16'h0005, 5);
      runSession("gappy", 40, -1);
      makeStream(16'h0003, 3);
      runSession("gappy_heavy", 70, -1);

      // start pulsed in the middle of the data phase is ignored.
      makeStream(16'h0003, 3);
      runSession("start_mid", 20, 7);

      // Reset after two of three words written, partway into the third.
      makeStream(16'h0003, 3);
      obsAddr.delete();
      obsData.delete();
      pulseStart();
      applyStimulus(0, -1, 2 + 8 + 3);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("abort_pre_writes", obsAddr.size(), 2);
      reset      = 1'b1;
      byte_valid = 1'b1;
      byte_data  = stream[13];
      @(posedge clk); #1;
      reset = 1'b0;
      checkResetOutputs("abort");
      repeat (10) @(posedge clk);
      #1;
      byte_valid = 1'b0;
      checkOutput("abort_no_write", obsAddr.size(), 2);
      checkOutput("abort_idle_hold", cpu_hold, 0);

      // reset wins over start in the same cycle.
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      checkOutput("rst_vs_start_hold", cpu_hold, 0);
      @(posedge clk); #1;
      checkOutput("rst_vs_start_ready", byte_ready, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width; DEPTH = 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a load session.
REQ-005 byte_valid  input  1  a byte is offered on byte_data.
REQ-006 byte_data  input  8  stream byte.
REQ-007 byte_ready  output  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready.
REQ-008 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 im_addr  output  ADDR_W  word address for the write.
REQ-010 im_wdata  output  32  instruction word written.
REQ-011 cpu_hold  output  1  holds the CPU (PC and register writes) while high.
REQ-012 done  output  1  one-cycle pulse on successful completion.
REQ-013 error  output  1  level, set on bad length header.

Function
REQ-014 Stream format: 2-byte big-endian word count N, then N words of 4 bytes each, MSB first.
REQ-015 States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
REQ-016 IDLE: byte_ready=0, cpu_hold=0; start -> LEN_HI.
REQ-017 LEN_HI: byte_ready=1; on transfer, latch count[15:8] -> LEN_LO.
REQ-018 LEN_LO: byte_ready=1; on transfer, latch count[7:0]; N==0 or N>DEPTH -> ERR, else -> DATA with word index 0 and byte index 0.
REQ-019 DATA: byte_ready=1; each transfer shifts byte into 32-bit assembly register (first byte ends in [31:24]); 4th transfer -> WRITE.
REQ-020 WRITE: byte_ready=0; im_we=1, im_addr=word index, im_wdata=assembled word for exactly one cycle; next state DATA if index+1<N, else DONE; index increments.
REQ-021 Latency: im_we asserts the cycle after the 4th byte of a word is accepted.
REQ-022 DONE: done=1 and cpu_hold=0 for one cycle, then IDLE.
REQ-023 ERR: error=1, cpu_hold=1, byte_ready=0; start -> LEN_HI with error cleared; all other inputs ignored.
REQ-024 cpu_hold=1 in LEN_HI, LEN_LO, DATA, WRITE, ERR.
REQ-025 start is ignored in LEN_HI, LEN_LO, DATA, WRITE, DONE (no restart mid-session).
REQ-026 byte_valid=0 stalls any state indefinitely without state change; no timeout.
REQ-027 N==DEPTH is legal; last write uses im_addr=DEPTH-1, no wrap-around.
REQ-028 Bytes offered while byte_ready=0 are not consumed; im_we never asserts outside WRITE.

Reset
REQ-029 reset forces IDLE; byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=0, done=0, error=0; count, indices, assembly register cleared.
REQ-030 reset mid-session aborts it next edge; words already written stay written; no further im_we.
REQ-031 reset has priority over start in the same cycle.

Verification
REQ-032 start; stream 00 02 20 08 00 05 AC 08 00 00 -> im_we at addr 0 data 0x20080005, then addr 1 data 0xAC080000; done pulse; cpu_hold 1 until done.
REQ-033 start; header 00 00 -> error=1, cpu_hold=1, no im_we; then start; header 00 01 + 4 bytes -> error clears, one write, done.
REQ-034 ADDR_W=8, header 01 01 (257) -> ERR; header 01 00 (256) -> 256 writes, last im_addr=0xFF.
REQ-035 byte_valid toggled randomly mid-word -> same im_wdata/im_addr sequence as gap-free stream; byte_ready=0 in each WRITE cycle.
REQ-036 reset asserted after 2 of 3 words written -> IDLE next cycle, all outputs at reset values, no third write.
REQ-037 start pulsed during DATA -> ignored; session completes unchanged.
